// File: rtl/training_sequencer.sv
// Training-loop sequencer: walks N_SAMPLES samples per epoch through apply/settle/evaluate and counts epochs.
// Optional early stop on a zero-error epoch is enabled by defining TRAINING_SEQUENCER_EARLY_STOP_EN.
module training_sequencer #(
  parameter int unsigned N_SAMPLES     = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_EPOCHS    = 1000,
  parameter logic [31:0] ACTIVE_MASK   = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sample_ok,
  output logic [7:0]  sample_idx,
  output logic [31:0] enabled,
  output logic        fwd_valid,
  output logic        learn_en,
  output logic [15:0] epoch,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic        done,
  output logic        converged
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    APPLY     = 3'd1,
    SETTLE    = 3'd2,
    EVAL      = 3'd3,
    EPOCH_END = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam logic [7:0]  LAST_IDX    = 8'(N_SAMPLES - 1);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] EPOCH_LIMIT = 16'(MAX_EPOCHS);

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  err_q;
  logic [7:0]  err_d;
  logic [7:0]  settle_q;
  logic [15:0] epoch_q;
  logic [15:0] epoch_d;
  logic [31:0] enabled_q;
  logic        fwd_q;
  logic        busy_q;
  logic        done_q;
  logic        conv_q;
  logic        stop_d;

  // Saturating increments and the end-of-run decision taken in EPOCH_END
  always_comb begin
    epoch_d = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
    stop_d  = (epoch_d >= EPOCH_LIMIT) || (err_q == 8'd0);
`else
    stop_d  = (epoch_d >= EPOCH_LIMIT);
`endif
  end

  // Sequencer FSM with all status outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'd0;
      err_q     <= 8'd0;
      settle_q  <= 8'd0;
      epoch_q   <= 16'd0;
      enabled_q <= 32'h0;
      fwd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
    end else if (busy_q && abort) begin
      state_q   <= DONE;
      settle_q  <= 8'd0;
      enabled_q <= 32'h0;
      fwd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b1;
      conv_q    <= 1'b0;
    end else begin
      fwd_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_q   <= APPLY;
            idx_q     <= 8'd0;
            err_q     <= 8'd0;
            epoch_q   <= 16'd0;
            enabled_q <= ACTIVE_MASK;
            fwd_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
          end
        end
        APPLY: begin
          state_q  <= SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= EVAL;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        EVAL: begin
          if (!sample_ok) begin
            err_q <= err_d;
          end
          if (idx_q < LAST_IDX) begin
            idx_q   <= idx_q + 8'd1;
            state_q <= APPLY;
            fwd_q   <= 1'b1;
          end else begin
            state_q <= EPOCH_END;
          end
        end
        EPOCH_END: begin
          epoch_q <= epoch_d;
          idx_q   <= 8'd0;
          if (stop_d) begin
            // err_count is kept so the last epoch's result stays visible in DONE
            state_q   <= DONE;
            enabled_q <= 32'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            conv_q    <= (err_q == 8'd0);
          end else begin
            state_q <= APPLY;
            err_q   <= 8'd0;
            fwd_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          enabled_q <= 32'h0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // learn_en must coincide with the EVAL cycle itself, so it is decoded from the state register
  assign learn_en   = (state_q == EVAL) && !sample_ok && !abort && !rst;
  assign sample_idx = idx_q;
  assign enabled    = enabled_q;
  assign fwd_valid  = fwd_q;
  assign epoch      = epoch_q;
  assign err_count  = err_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench for training_sequencer: randomized sample_ok patterns, aborts and resets,
// expected events derived from cycle arithmetic over the sample/epoch schedule.
module tb_training_sequencer;
  localparam int N      = 4;
  localparam int S      = 2;
  localparam int MAXE   = 5;
  localparam logic [31:0] MASK = 32'hA5A5_0F03;
  localparam int SP     = S + 2;
  localparam int EP_LEN = N * SP + 1;
  localparam int K_FWD   = 0;
  localparam int K_LEARN = 1;
  localparam int K_DONE  = 2;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    int kind;
    int idx;
    int ep;
    int err;
    int conv;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, sample_ok;
  logic [7:0]  sample_idx, err_count;
  logic [31:0] enabled;
  logic        fwd_valid, learn_en, busy, done, converged;
  logic [15:0] epoch;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  bit  ok_tab [MAXE][N];

  training_sequencer #(
    .N_SAMPLES(N), .SETTLE_CYCLES(S), .MAX_EPOCHS(MAXE), .ACTIVE_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_ok(sample_ok),
    .sample_idx(sample_idx), .enabled(enabled), .fwd_valid(fwd_valid), .learn_en(learn_en),
    .epoch(epoch), .err_count(err_count), .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int kind, input int idx, input int ep, input int err, input int conv);
    ev_t ev;
    ev.kind = kind; ev.idx = idx; ev.ep = ep; ev.err = err; ev.conv = conv;
    exp_q.push_back(ev);
  endfunction

  task automatic check_reset_vals();
    chk("rst_idx",   32'(sample_idx), 0);
    chk("rst_en",    enabled,         0);
    chk("rst_fwd",   32'(fwd_valid),  0);
    chk("rst_learn", 32'(learn_en),   0);
    chk("rst_epoch", 32'(epoch),      0);
    chk("rst_err",   32'(err_count),  0);
    chk("rst_busy",  32'(busy),       0);
    chk("rst_done",  32'(done),       0);
    chk("rst_conv",  32'(converged),  0);
  endtask

  // mode: 0 all ok, 1 all bad, 2 bad at last sample of first two epochs, 3 random falling error rate
  // ab_c / rst_c: -1 none, -2 random cycle within the run, else the cycle index after the first APPLY
  task automatic run(input int mode, input int ab_c, input int rst_c);
    int e_tot, last_err, errs, e, r, i, ph;
    int x_ep, x_err, x_conv;
    bit is_eval, okv, ended, was_rst;
    for (int ee = 0; ee < MAXE; ee++) begin
      for (int ii = 0; ii < N; ii++) begin
        case (mode)
          0:       ok_tab[ee][ii] = 1'b1;
          1:       ok_tab[ee][ii] = 1'b0;
          2:       ok_tab[ee][ii] = !((ii == N - 1) && (ee < 2));
          default: ok_tab[ee][ii] = (int'($urandom_range(0, 7)) >= 6 - 2 * ee);
        endcase
      end
    end
    e_tot = MAXE;
    last_err = 0;
    for (int ee = 0; ee < MAXE; ee++) begin
      errs = 0;
      for (int ii = 0; ii < N; ii++) errs += ok_tab[ee][ii] ? 0 : 1;
      if ((ee + 1 >= MAXE) || (EARLY && errs == 0)) begin
        e_tot = ee + 1;
        last_err = errs;
        break;
      end
    end
    if (ab_c == -2) ab_c = $urandom_range(0, e_tot * EP_LEN - 1);
    if (rst_c == -2) rst_c = $urandom_range(0, e_tot * EP_LEN - 1);
    x_ep = e_tot; x_err = last_err; x_conv = (last_err == 0) ? 1 : 0;
    ended = 1'b0; was_rst = 1'b0;

    @(posedge clk); #1; start = 1'b1; abort = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < e_tot * EP_LEN; c++) begin
      e = c / EP_LEN; r = c % EP_LEN; i = r / SP; ph = r % SP;
      errs = 0;
      for (int j = 0; j < ((r < N * SP) ? i : N); j++) errs += ok_tab[e][j] ? 0 : 1;
      is_eval = (r < N * SP) && (ph == SP - 1);
      if (r < N * SP && ph == 0) push_ev(K_FWD, i, e, errs, 0);
      okv = ($urandom_range(0, 1) == 1);
      if (is_eval) okv = ok_tab[e][i];
      if (c == rst_c) begin
        sample_ok = 1'b1; start = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_reset_vals();
        ended = 1'b1; was_rst = 1'b1;
        break;
      end
      sample_ok = okv;
      if (c == ab_c) begin
        start = 1'b0; abort = 1'b1;
        push_ev(K_DONE, 0, e, errs, 0);
        x_ep = e; x_err = errs; x_conv = 0;
        @(posedge clk); #1; abort = 1'b0;
        ended = 1'b1;
        break;
      end
      start = ($urandom_range(0, 1) == 1);
      if (is_eval && !okv) push_ev(K_LEARN, i, e, errs, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!ended) push_ev(K_DONE, 0, e_tot, last_err, x_conv);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    if (was_rst) begin
      chk("post_rst_busy", 32'(busy), 0);
    end else begin
      chk("hold_done",  32'(done),      1);
      chk("hold_busy",  32'(busy),      0);
      chk("hold_epoch", 32'(epoch),     x_ep);
      chk("hold_err",   32'(err_count), x_err);
      chk("hold_conv",  32'(converged), x_conv);
    end
  endtask

  // Monitor: pops one expected event per observed pulse or done rising edge
  initial begin : monitor
    ev_t ev;
    bit  done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fwd_valid || learn_en || (done && !done_prev)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: fwd=%0b learn=%0b done=%0b idx=%0d, nothing expected at %0t",
                   fwd_valid, learn_en, done, sample_idx, $time);
        end else begin
          ev = exp_q.pop_front();
          if (fwd_valid) begin
            chk("fwd_kind",  K_FWD,           ev.kind);
            chk("fwd_idx",   32'(sample_idx), ev.idx);
            chk("fwd_epoch", 32'(epoch),      ev.ep);
            chk("fwd_err",   32'(err_count),  ev.err);
            chk("fwd_busy",  32'(busy),       1);
            chk("fwd_en",    enabled,         MASK);
          end else if (learn_en) begin
            chk("learn_kind",  K_LEARN,         ev.kind);
            chk("learn_idx",   32'(sample_idx), ev.idx);
            chk("learn_epoch", 32'(epoch),      ev.ep);
            chk("learn_err",   32'(err_count),  ev.err);
          end else begin
            chk("done_kind",  K_DONE,          ev.kind);
            chk("done_epoch", 32'(epoch),      ev.ep);
            chk("done_err",   32'(err_count),  ev.err);
            chk("done_conv",  32'(converged),  ev.conv);
            chk("done_busy",  32'(busy),       0);
            chk("done_en",    enabled,         0);
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sample_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_start_abort_busy", 32'(busy), 0);
    chk("idle_start_abort_done", 32'(done), 0);
    run(0, -1, -1);
    run(1, -1, -1);
    run(2, -1, -1);
    run(3, 2 * SP + 1, -1);
    run(3, -1, 2 * SP - 1);
    run(0, -1, -1);
    for (int k = 0; k < 12; k++) begin
      run(3, ($urandom_range(0, 3) == 0) ? -2 : -1, ($urandom_range(0, 5) == 0) ? -2 : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, number of training samples per epoch (range 1..256).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, forward-path settle wait in cycles (range 1..255).
REQ-003 SHALL have parameter MAX_EPOCHS, default 1000, epoch limit (range 1..65535).
REQ-004 SHALL have parameter ACTIVE_MASK, default 32'h0000_0003, neuron input-enable pattern.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port start, input, 1, begin a training run when idle.
REQ-008 SHALL have port abort, input, 1, terminate the run at the next edge.
REQ-009 SHALL have port sample_ok, input, 1, neuron output matches expected for the current sample.
REQ-010 SHALL have port sample_idx, output, 8, index of the sample presented to the neuron.
REQ-011 SHALL have port enabled, output, 32, input-enable vector driven to the neuron.
REQ-012 SHALL have port fwd_valid, output, 1, one-cycle pulse: new sample applied.
REQ-013 SHALL have port learn_en, output, 1, one-cycle pulse: gate backprop weight update.
REQ-014 SHALL have port epoch, output, 16, completed-epoch count.
REQ-015 SHALL have port err_count, output, 8, mismatches in the current epoch.
REQ-016 SHALL have ports busy, done, converged, output, 1 each: run active; run finished (level, until next start); finished with a zero-error epoch.

Function
REQ-017 SHALL implement states IDLE, APPLY, SETTLE, EVAL, EPOCH_END, DONE.
REQ-018 IDLE: start=1 -> APPLY; clears sample_idx, epoch, err_count, done, converged; busy=1 from next cycle.
REQ-019 APPLY: fwd_valid=1 for exactly this cycle; -> SETTLE with settle counter loaded to SETTLE_CYCLES-1.
REQ-020 SETTLE: counter decrements each cycle; -> EVAL the cycle after it reads 0 (APPLY to EVAL = SETTLE_CYCLES+1 cycles).
REQ-021 EVAL: sample sample_ok once; if 0, err_count increments (saturating at 255) and learn_en=1 this cycle; if 1, learn_en=0.
REQ-022 EVAL: sample_idx < N_SAMPLES-1 -> increment sample_idx, -> APPLY; else -> EPOCH_END.
REQ-023 EPOCH_END: epoch increments (saturating 65535); sample_idx wraps to 0; err_count cleared on the transition to APPLY.
REQ-024 EPOCH_END -> DONE when epoch reaches MAX_EPOCHS or the early-stop condition (REQ-033) holds; else -> APPLY.
REQ-025 DONE: done=1, busy=0, err_count holds last epoch's value; start=1 -> behaves as IDLE start.
REQ-026 enabled SHALL equal ACTIVE_MASK whenever busy=1 and 32'h0 otherwise.
REQ-027 abort=1 in any busy state -> DONE next edge, converged=0, no learn_en pulse that cycle; abort takes priority over all transitions.
REQ-028 start while busy SHALL be ignored; start and abort together in IDLE -> remain IDLE.
REQ-029 sample_ok SHALL be ignored outside EVAL.

Reset
REQ-030 rst=1 at a rising edge -> IDLE regardless of state, including mid-SETTLE or mid-EVAL.
REQ-031 Reset values: sample_idx=0, enabled=0, fwd_valid=0, learn_en=0, epoch=0, err_count=0, busy=0, done=0, converged=0, settle counter=0.
REQ-032 rst SHALL have priority over start and abort.

Configuration
REQ-033 Macro TRAINING_SEQUENCER_EARLY_STOP_EN defined: EPOCH_END with err_count=0 -> DONE with converged=1; undefined: run always completes MAX_EPOCHS, converged=1 only if the final epoch had err_count=0.

Verification
REQ-034 Defaults, sample_ok held 1, macro defined: start -> fwd_valid pulses at sample_idx 0,1,2,3 spaced 4 cycles apart, no learn_en, done with epoch=1, converged=1.
REQ-035 Defaults, sample_ok=0 only at sample_idx 3 for epochs 1-2 -> learn_en pulses once per epoch, err_count=1 at first two EPOCH_ENDs, done at epoch=3, converged=1.
REQ-036 MAX_EPOCHS=5, sample_ok held 0 -> 20 learn_en pulses, done with epoch=5, err_count=4, converged=0.
REQ-037 abort asserted during SETTLE of sample 2, epoch 0 -> DONE next edge, no further fwd_valid/learn_en, epoch=0, converged=0.
REQ-038 rst asserted during EVAL -> all outputs at reset values next cycle; start afterwards restarts at sample_idx=0, epoch=0.
REQ-039 Macro undefined, MAX_EPOCHS=3, sample_ok held 1 -> runs 3 epochs, 12 fwd_valid pulses, converged=1.
